ic_test_sequencer: RTL

- Automatic sequencer for the logic IC tester.
- On a start command it latches the selected IC type and drives the shared gate inputs a/b through all four input vectors.
- After each vector it waits a settle time, then samples the four gate outputs of the IC under test and checks them against the expected truth table.
- It accumulates per-gate mismatches and reports an overall pass/fail; it replaces manual entry of a, b and the observed outputs.

---
 rtl/ic_test_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ic_test_sequencer.sv
// Logic IC tester sequencer: walks {a,b} through all four vectors, samples the
// four gate outputs after a settle delay and accumulates per-gate mismatches.
module ic_test_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] ic_sel,
  input  logic [3:0] dut_y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       fail,
  output logic       invalid,
  output logic [3:0] gate_fail,
  output logic [1:0] vec_idx
);

  localparam int NUM_GATES = 4;
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
  localparam logic [2:0] SEL_INVALID = 3'b111;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t                 state, state_d;
  logic [2:0]             sel_q, sel_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic [1:0]             vec_d;
  logic                   busy_d, done_d, pass_d, fail_d, inv_d;
  logic [NUM_GATES-1:0]   gf_d, mis, gf_smp;
  logic                   exp_y;

  // Gate inputs are the vector index itself, so they are registered by construction.
  assign {a, b} = vec_idx;

  always_comb begin
    exp_y = 1'b0;
    case (sel_q)
      3'd0:    exp_y = ~(a & b);
      3'd1:    exp_y = ~(a | b);
      3'd2:    exp_y = ~a;
      3'd3:    exp_y = a & b;
      3'd4:    exp_y = a | b;
      3'd5:    exp_y = a ^ b;
      3'd6:    exp_y = ~(a ^ b);
      default: exp_y = 1'b0;
    endcase
  end

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
    assign mis[g] = (dut_y[g] != exp_y);
  end
  assign gf_smp = gate_fail | mis;

  always_comb begin
    state_d = state;
    sel_d   = sel_q;
    cnt_d   = cnt;
    vec_d   = vec_idx;
    busy_d  = busy;
    done_d  = 1'b0;
    pass_d  = pass;
    fail_d  = fail;
    inv_d   = invalid;
    gf_d    = gate_fail;
    if (state != IDLE && abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      vec_d   = 2'd0;
      busy_d  = 1'b0;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
      inv_d   = 1'b0;
      gf_d    = '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sel_d  = ic_sel;
          vec_d  = 2'd0;
          busy_d = 1'b1;
          pass_d = 1'b0;
          if (ic_sel == SEL_INVALID) begin
            inv_d   = 1'b1;
            fail_d  = 1'b1;
            gf_d    = '1;
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            inv_d   = 1'b0;
            fail_d  = 1'b0;
            gf_d    = '0;
            cnt_d   = SETTLE_LD;
            state_d = SETTLE;
          end
        end
        SETTLE: begin
          cnt_d = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_d = SAMPLE;
        end
        SAMPLE: begin
          gf_d = gf_smp;
          if (vec_idx != 2'd3) begin
            vec_d   = vec_idx + 2'd1;
            cnt_d   = SETTLE_LD;
            state_d = SETTLE;
          end else begin
            // Verdict uses the post-sample mismatch vector so it is valid with done.
            pass_d  = (gf_smp == '0) && !invalid;
            fail_d  = !((gf_smp == '0) && !invalid);
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
        DONE: begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel_q     <= 3'd0;
      cnt       <= '0;
      vec_idx   <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      invalid   <= 1'b0;
      gate_fail <= '0;
    end else begin
      state     <= state_d;
      sel_q     <= sel_d;
      cnt       <= cnt_d;
      vec_idx   <= vec_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      fail      <= fail_d;
      invalid   <= inv_d;
      gate_fail <= gf_d;
    end
  end

endmodule
